// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down counter with enable, clamped load, wrap or saturate, and status flags
module mod_updown_counter #(
  parameter int     WIDTH    = 3,
  parameter longint MODULUS  = 8,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             at_limit
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d, lim_q, lim_d, at_max, at_min, at_end;
  assign at_max = count_q == MAX;
  assign at_min = count_q == '0;
  assign at_end = up ? at_max : at_min;
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    lim_d   = lim_q;
    if (load) begin
      count_d = load_val > MAX ? MAX : load_val;
      lim_d   = 1'b0;
    end else if (en) begin
      lim_d = SATURATE && at_end;
      if (!at_end) count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      else if (!SATURATE) begin
        count_d = up ? '0 : MAX;
        wrap_d  = 1'b1;
      end
    end
  end
  // async clear also discards any wrap pulse that was about to be presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      lim_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      lim_q   <= lim_d;
    end
  end
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign at_limit = lim_q;
  assign tc       = at_end;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: drives four counter variants in lockstep against a behavioural model via a scoreboard
module tb_mod_updown_counter;
  localparam int N = 4;
  localparam int M [N] = '{8, 6, 6, 2};
  localparam bit S [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
  typedef struct {int c; bit w; bit a;} st_t;
  logic       clk = 1'b0, reset = 1'b0, en = 1'b1, up = 1'b1, load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] cnt [N];
  logic       tc [N], wr [N], al [N];
  st_t        st [N];
  logic [N-1:0][5:0] sb [$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_m8 (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(cnt[0]), .tc(tc[0]), .wrap(wr[0]), .at_limit(al[0]));
  mod_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) u_m6 (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(cnt[1]), .tc(tc[1]), .wrap(wr[1]), .at_limit(al[1]));
  mod_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) u_m6s (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(cnt[2]), .tc(tc[2]), .wrap(wr[2]), .at_limit(al[2]));
  mod_updown_counter #(.WIDTH(3), .MODULUS(2), .SATURATE(1'b0)) u_m2 (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(cnt[3]), .tc(tc[3]), .wrap(wr[3]), .at_limit(al[3]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic st_t nxt(input st_t s, input int m, input bit sat, input bit e, input bit u, input bit l, input int lv);
    st_t r;
    r = s;
    r.w = 1'b0;
    if (l) begin
      r.c = lv >= m ? m - 1 : lv;
      r.a = 1'b0;
    end else if (e) begin
      r.a = 1'b0;
      if (u && s.c < m - 1) r.c = s.c + 1;
      else if (!u && s.c > 0) r.c = s.c - 1;
      else if (sat) r.a = 1'b1;
      else begin
        r.c = u ? 0 : m - 1;
        r.w = 1'b1;
      end
    end
    return r;
  endfunction
  function automatic logic [5:0] pack(input st_t s, input int m, input bit u);
    return {u ? s.c == m - 1 : s.c == 0, s.a, s.w, 3'(s.c)};
  endfunction
  function automatic logic [5:0] obs(input int k);
    return {tc[k], al[k], wr[k], cnt[k]};
  endfunction
  task automatic step(input bit e, input bit u, input bit l, input logic [2:0] lv, input string tag);
    logic [N-1:0][5:0] ex;
    en = e; up = u; load = l; load_val = lv;
    for (int k = 0; k < N; k++) begin
      st[k] = nxt(st[k], M[k], S[k], e, u, l, int'(lv));
      ex[k] = pack(st[k], M[k], u);
    end
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    for (int k = 0; k < N; k++) check($sformatf("%s[%0d]", tag, k), 32'(obs(k)), 32'(ex[k]));
  endtask
  task automatic mid_reset(input string tag);
    #3 reset = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      st[k] = '{0, 1'b0, 1'b0};
      check($sformatf("%s[%0d]", tag, k), 32'(obs(k)), 32'(pack(st[k], M[k], up)));
    end
    #2 reset = 1'b1;
  endtask
  initial begin
    for (int k = 0; k < N; k++) st[k] = '{0, 1'b0, 1'b0};
    #7;
    for (int k = 0; k < N; k++) check($sformatf("reset[%0d]", k), 32'(obs(k)), 32'(pack(st[k], M[k], 1'b1)));
    #3 reset = 1'b1;
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 3'd0, "up");
    step(1'b1, 1'b0, 1'b0, 3'd0, "sat_release");
    step(1'b1, 1'b1, 1'b1, 3'd3, "load3");
    step(1'b1, 1'b0, 1'b1, 3'd7, "load7");
    step(1'b0, 1'b1, 1'b1, 3'd0, "load0");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 3'd0, "down");
    step(1'b0, 1'b1, 1'b1, 3'd2, "load2");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 3'd0, "hold");
    step(1'b1, 1'b1, 1'b0, 3'd0, "resume");
    step(1'b1, 1'b1, 1'b1, 3'd0, "load0b");
    step(1'b1, 1'b1, 1'b0, 3'd0, "dirchg");
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 1'($urandom), $urandom_range(7) == 0, 3'($urandom), "rand");
    step(1'b1, 1'b1, 1'b1, 3'd5, "pre_rst");
    mid_reset("rst_at5");
    step(1'b1, 1'b1, 1'b0, 3'd0, "post_rst1");
    step(1'b1, 1'b1, 1'b0, 3'd0, "post_rst2");
    step(1'b1, 1'b1, 1'b1, 3'd7, "pre_wrap");
    step(1'b1, 1'b1, 1'b0, 3'd0, "wrap_pend");
    mid_reset("rst_wrap");
    step(1'b1, 1'b1, 1'b0, 3'd0, "post_rst3");
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the 3-bit free-running binary counter. Modulo-N up/down counter with clock enable, synchronous parallel load, selectable wrap or saturate at the limits, and terminal-count and wrap status. Used as a reusable sequencing, timing and address counter in control paths.

Parameters:
WIDTH, 3, counter width in bits; legal range is 1 to 32.
MODULUS, 8, count range is 0 to MODULUS-1; legal range is 2 to 2^WIDTH; checked at elaboration.
SATURATE, 0, 0 wraps at the limits; 1 holds at the limits.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (asserted when 0).
en  input  1  count enable.
up  input  1  1 counts up, 0 counts down; sampled on each enabled edge.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value to load.
count  output  WIDTH  registered counter value.
tc  output  1  combinational terminal count: (up && count==MODULUS-1) || (!up && count==0).
wrap  output  1  registered one-cycle pulse, high for the cycle after a wrap event.
at_limit  output  1  registered; high while saturated and a further step was blocked.

Behaviour:
- Reset (reset==0), asynchronous: count=0, wrap=0, at_limit=0 immediately, independent of clk. Release is synchronous to the next rising edge; the first update occurs on the first edge with reset==1.
- Priority on each rising edge: load > en > hold.
- load==1: count <= (load_val >= MODULUS) ? MODULUS-1 : load_val (clamped). wrap<=0, at_limit<=0. The en and up inputs are ignored.
- en==1, load==0, up==1:
  - If count < MODULUS-1: count <= count+1.
  - At MODULUS-1 with SATURATE=0: count <= 0, wrap<=1.
  - At MODULUS-1 with SATURATE=1: count holds, at_limit<=1.
- en==1, load==0, up==0:
  - If count > 0: count <= count-1.
  - At 0 with SATURATE=0: count <= MODULUS-1, wrap<=1.
  - At 0 with SATURATE=1: count holds, at_limit<=1.
- All other enabled steps clear wrap and at_limit.
- en==0, load==0: count holds, wrap<=0, at_limit holds.
- Arithmetic:
  - Performed in WIDTH bits; no intermediate value exceeds MODULUS-1.
  - With MODULUS==2^WIDTH, natural rollover equals modulo behaviour.
- Latency: count changes one edge after the qualifying inputs; tc follows count and up combinationally; wrap is exactly one cycle wide per wrap event.
- Back-to-back wraps: with MODULUS=2, up, en=1 continuously, wrap is high every other cycle.
- A direction change at a limit takes effect on the same edge. Example: at 0 with up=1, next value is 1 and there is no wrap.
- Reset asserted mid-count: outputs clear immediately; a pending wrap pulse is discarded.
- With the default parameters and en=1, up=1, load=0, behaviour matches the legacy 3-bit counter cycle for cycle, including the increment on the first edge after reset release.

Test Plan:
1. Defaults; hold reset=0 for 10 ns, then release with en=1, up=1 -> count 0, 1, 2, ... 7, 0 on successive edges; wrap high exactly in the cycle count returns to 0; tc high while count==7.
2. MODULUS=6, en=1, up=0 from count 0 -> sequence 5, 4, 3, 2, 1, 0, 5; wrap pulses once per 0->5 transition; tc high at count 0.
3. MODULUS=6, SATURATE=1, up=1 from 0 -> count reaches 5 and holds for 3 further edges; at_limit high from the second edge at 5 onward; wrap never asserts. Then up=0 -> count 4 and at_limit clears.
4. Load behaviour: load=1, load_val=3 with en=1 -> count 3 next edge, no increment. load_val=7 with MODULUS=6 -> count clamped to 5. load and en both high -> load wins.
5. en toggling: en=0 for 4 cycles at count 2 -> count stays 2 and wrap stays 0; en=1 -> count 3.
6. Async reset at count 5, asserted mid-cycle between edges -> count=0 and wrap=0 before the next clk edge; after release, counting resumes 1, 2, ...
